// File: rtl/regfile_multiport_if.sv
// Decode/writeback side bundle of the multi-ported register file.
// Field packing: port i of a flat vector sits at [i*W +: W].
interface regfile_multiport_if #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 32,
   parameter int NUM_READ  = 2,
   parameter int NUM_WRITE = 2
);
   localparam int AW = $clog2(DEPTH);

   logic                       ClearReq;
   logic                       Ready;
   logic [NUM_READ*AW-1:0]     ReadNum;
   logic [NUM_READ*WIDTH-1:0]  ReadData;
   logic [NUM_READ-1:0]        ReadBusy;
   logic [NUM_WRITE-1:0]       WriteEn;
   logic [NUM_WRITE*AW-1:0]    WriteNum;
   logic [NUM_WRITE*WIDTH-1:0] WriteData;
   logic                       ReserveEn;
   logic [AW-1:0]              ReserveNum;

   modport master (
      output ClearReq, ReadNum, WriteEn, WriteNum, WriteData, ReserveEn, ReserveNum,
      input  Ready, ReadData, ReadBusy
   );

   modport slave (
      input  ClearReq, ReadNum, WriteEn, WriteNum, WriteData, ReserveEn, ReserveNum,
      output Ready, ReadData, ReadBusy
   );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-ported integer register file with busy scoreboard, write->read bypass
// and a sequential clear engine that zeroes the array after reset or on request.
module regfileReadPort #(
   parameter int WIDTH     = 32,
   parameter int AW        = 5,
   parameter int NUM_WRITE = 2,
   parameter int BYPASS    = 1,
   parameter int ZERO_REG  = 1
) (
   input  logic                                run,
   input  logic [AW-1:0]                       addr,
   input  logic [WIDTH-1:0]                    arrData,
   input  logic                                arrBusy,
   input  logic [NUM_WRITE-1:0]                wrEn,
   input  logic [NUM_WRITE-1:0][AW-1:0]        wrNum,
   input  logic [NUM_WRITE-1:0][WIDTH-1:0]     wrData,
   output logic [WIDTH-1:0]                    data,
   output logic                                busy
);
   always_comb begin
      data = arrData;
      busy = arrBusy;
      // Ascending scan so the highest matching write port wins the forward.
      if (BYPASS != 0)
         for (int j = 0; j < NUM_WRITE; j++)
            if (wrEn[j] && wrNum[j] == addr) begin
               data = wrData[j];
               busy = 1'b0;
            end
      if (!run || (ZERO_REG != 0 && addr == '0)) begin
         data = '0;
         busy = 1'b0;
      end
   end
endmodule

module regfile_multiport #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 32,
   parameter int NUM_READ  = 2,
   parameter int NUM_WRITE = 2,
   parameter int BYPASS    = 1,
   parameter int ZERO_REG  = 1
) (
   input logic CLK,
   input logic RST,
   regfile_multiport_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] RUN   = 1'b1;

   logic [0:0]                          state;
   logic [AW-1:0]                       clrIdx;
   logic [DEPTH-1:0]                    busy, busyNext;
   logic [WIDTH-1:0]                    regs [DEPTH];
   logic [NUM_READ-1:0][AW-1:0]         rdNum;
   logic [NUM_READ-1:0][WIDTH-1:0]      rdData;
   logic [NUM_READ-1:0]                 rdBusy;
   logic [NUM_WRITE-1:0][AW-1:0]        wrNum;
   logic [NUM_WRITE-1:0][WIDTH-1:0]     wrData;
   logic [NUM_WRITE-1:0]                wrOk;

   assign rdNum  = bus.ReadNum;
   assign wrNum  = bus.WriteNum;
   assign wrData = bus.WriteData;
   assign bus.ReadData = rdData;
   assign bus.ReadBusy = rdBusy;
   assign bus.Ready    = (state == RUN);

   always_comb
      for (int j = 0; j < NUM_WRITE; j++)
         wrOk[j] = bus.WriteEn[j] && !(ZERO_REG != 0 && wrNum[j] == '0);

   // Writeback retires the old producer; a same-cycle reserve is the new one and wins.
   always_comb begin
      busyNext = busy;
      for (int j = 0; j < NUM_WRITE; j++)
         if (wrOk[j]) busyNext[wrNum[j]] = 1'b0;
      if (bus.ReserveEn && !(ZERO_REG != 0 && bus.ReserveNum == '0))
         busyNext[bus.ReserveNum] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= CLEAR;
         clrIdx <= '0;
         busy   <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clrIdx <= clrIdx + 1'b1;
               if (clrIdx == AW'(DEPTH - 1)) state <= RUN;
            end
            default: begin
               if (bus.ClearReq) begin
                  state  <= CLEAR;
                  clrIdx <= '0;
                  busy   <= '0;
               end else begin
                  busy <= busyNext;
               end
            end
         endcase
      end
   end

   // Later ports are assigned last, so the highest index wins on address clashes.
   always_ff @(posedge CLK) begin
      if (state == CLEAR)
         regs[clrIdx] <= '0;
      else
         for (int j = 0; j < NUM_WRITE; j++)
            if (wrOk[j]) regs[wrNum[j]] <= wrData[j];
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : gRd
      regfileReadPort #(
         .WIDTH(WIDTH), .AW(AW), .NUM_WRITE(NUM_WRITE), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
      ) uRd (
         .run     (state == RUN),
         .addr    (rdNum[i]),
         .arrData (regs[rdNum[i]]),
         .arrBusy (busy[rdNum[i]]),
         .wrEn    (bus.WriteEn),
         .wrNum   (wrNum),
         .wrData  (wrData),
         .data    (rdData[i]),
         .busy    (rdBusy[i])
      );
   end
endmodule

// File: tb/tb_regfile_multiport.sv
// Randomised and directed bench: a bypassing and a non-bypassing instance share
// one stimulus stream and are checked against a register-array reference model.
module tb_regfile_multiport;
   localparam int WIDTH = 32, DEPTH = 32, NR = 2, NW = 2, AW = 5;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   regfile_multiport_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_READ(NR), .NUM_WRITE(NW)) bus ();
   regfile_multiport_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_READ(NR), .NUM_WRITE(NW)) bus0 ();

   assign bus0.ClearReq   = bus.ClearReq;
   assign bus0.ReadNum    = bus.ReadNum;
   assign bus0.WriteEn    = bus.WriteEn;
   assign bus0.WriteNum   = bus.WriteNum;
   assign bus0.WriteData  = bus.WriteData;
   assign bus0.ReserveEn  = bus.ReserveEn;
   assign bus0.ReserveNum = bus.ReserveNum;

   regfile_multiport #(.BYPASS(1)) dut  (.CLK(CLK), .RST(RST), .bus(bus.slave));
   regfile_multiport #(.BYPASS(0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0.slave));

   // Reference model: register contents, busy flags, and cycles left in a clear.
   logic [WIDTH-1:0] mem [DEPTH];
   bit               busyM [DEPTH];
   bit               mReady;
   int               pending;
   int               checks = 0;
   int               errors = 0;

   task automatic ck(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic setIdle();
      bus.ClearReq = 1'b0; bus.ReadNum = '0; bus.WriteEn = '0; bus.WriteNum = '0;
      bus.WriteData = '0; bus.ReserveEn = 1'b0; bus.ReserveNum = '0;
   endtask

   task automatic setWr(int j, int a, logic [WIDTH-1:0] d);
      logic [AW-1:0] av;
      av = a[AW-1:0];
      bus.WriteEn[j] = 1'b1;
      bus.WriteNum[j*AW +: AW] = av;
      bus.WriteData[j*WIDTH +: WIDTH] = d;
   endtask

   task automatic setRd(int i, int a);
      logic [AW-1:0] av;
      av = a[AW-1:0];
      bus.ReadNum[i*AW +: AW] = av;
   endtask

   task automatic setRes(int a);
      logic [AW-1:0] av;
      av = a[AW-1:0];
      bus.ReserveEn = 1'b1;
      bus.ReserveNum = av;
   endtask

   task automatic modelRead(int a, bit byp, output logic [WIDTH-1:0] d, output logic b);
      d = '0; b = 1'b0;
      if (mReady && a != 0) begin
         d = mem[a]; b = busyM[a];
         if (byp)
            for (int j = 0; j < NW; j++)
               if (bus.WriteEn[j] && int'(bus.WriteNum[j*AW +: AW]) == a) begin
                  d = bus.WriteData[j*WIDTH +: WIDTH]; b = 1'b0;
               end
      end
   endtask

   task automatic checkAll();
      logic [WIDTH-1:0] d;
      logic b;
      int a;
      ck("ready_byp", {31'b0, bus.Ready}, {31'b0, mReady});
      ck("ready_nobyp", {31'b0, bus0.Ready}, {31'b0, mReady});
      for (int i = 0; i < NR; i++) begin
         a = int'(bus.ReadNum[i*AW +: AW]);
         modelRead(a, 1'b1, d, b);
         ck($sformatf("data_byp p%0d r%0d", i, a), bus.ReadData[i*WIDTH +: WIDTH], d);
         ck($sformatf("busy_byp p%0d r%0d", i, a), {31'b0, bus.ReadBusy[i]}, {31'b0, b});
         modelRead(a, 1'b0, d, b);
         ck($sformatf("data_nobyp p%0d r%0d", i, a), bus0.ReadData[i*WIDTH +: WIDTH], d);
         ck($sformatf("busy_nobyp p%0d r%0d", i, a), {31'b0, bus0.ReadBusy[i]}, {31'b0, b});
      end
   endtask

   task automatic modelEdge();
      int a;
      if (mReady) begin
         for (int j = 0; j < NW; j++)
            if (bus.WriteEn[j]) begin
               a = int'(bus.WriteNum[j*AW +: AW]);
               if (a != 0) begin
                  mem[a] = bus.WriteData[j*WIDTH +: WIDTH];
                  busyM[a] = 1'b0;
               end
            end
         if (bus.ReserveEn && bus.ReserveNum != '0) busyM[int'(bus.ReserveNum)] = 1'b1;
         if (bus.ClearReq) begin
            mReady = 1'b0;
            pending = DEPTH;
            foreach (busyM[k]) busyM[k] = 1'b0;
         end
      end else begin
         pending--;
         if (pending == 0) begin
            mReady = 1'b1;
            foreach (mem[k]) mem[k] = '0;
         end
      end
   endtask

   // Inputs are set at posedge+1, outputs checked at the falling edge.
   task automatic step();
      #4;
      checkAll();
      @(posedge CLK);
      modelEdge();
      #1;
      setIdle();
   endtask

   task automatic doReset();
      RST = 1'b1;
      #1;
      ck("ready_in_reset_byp", {31'b0, bus.Ready}, 32'd0);
      ck("ready_in_reset_nobyp", {31'b0, bus0.Ready}, 32'd0);
      mReady = 1'b0;
      pending = DEPTH;
      foreach (busyM[k]) busyM[k] = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic randStep(int span);
      setIdle();
      for (int j = 0; j < NW; j++)
         if ($urandom_range(0, 1) == 1) setWr(j, $urandom_range(0, span), $urandom);
      if ($urandom_range(0, 2) == 0) setRes($urandom_range(0, span));
      bus.ClearReq = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NR; i++) setRd(i, $urandom_range(0, span));
      step();
   endtask

   initial begin
      RST = 1'b0;
      setIdle();
      foreach (mem[k]) mem[k] = '0;
      @(posedge CLK);
      #1;
      doReset();
      // Power-up clear: Ready low for DEPTH edges, reads return zero.
      for (int n = 0; n < DEPTH; n++) begin
         setRd(0, n); setRd(1, DEPTH - 1 - n); setWr(0, n, 32'hDEAD0000 + n);
         step();
      end
      setRd(0, 31); step();

      // Bypass vs array-only read of a fresh write.
      setWr(0, 5, 32'h1234); setRd(0, 5); setRd(1, 5); step();
      setRd(0, 5); step();

      // Highest write port wins; r0 is hardwired to zero.
      setWr(0, 7, 32'hA); setWr(1, 7, 32'hB); setRd(0, 7); step();
      setRd(0, 7); setWr(0, 0, 32'hFF); setRd(1, 0); step();
      setRd(0, 7); setRd(1, 0); step();

      // Scoreboard: reserve, release, reserve+write same cycle, reserve r0.
      setRes(3); setRd(0, 3); step();
      setRd(0, 3); step();
      setWr(1, 3, 32'h33); setRd(0, 3); step();
      setRd(0, 3); step();
      setRes(3); setWr(0, 3, 32'h44); setRd(0, 3); step();
      setRd(0, 3); step();
      setRes(0); setRd(0, 0); step();
      setRd(0, 0); step();

      // Clear request with live data and a busy register; traffic during clear is dropped.
      setWr(0, 9, 32'h55); step();
      setRes(12); setRd(0, 9); step();
      bus.ClearReq = 1'b1; setRd(0, 9); setRd(1, 12); step();
      for (int n = 0; n < DEPTH; n++) begin
         setWr(0, 9, 32'h99); setWr(1, 12, n); setRes(9); bus.ClearReq = 1'b1;
         setRd(0, 9); setRd(1, 12);
         step();
      end
      setRd(0, 9); setRd(1, 12); step();

      // Reset part-way through a clear restarts the full sweep.
      setWr(0, 20, 32'h2020); step();
      bus.ClearReq = 1'b1; step();
      for (int n = 0; n < 10; n++) step();
      doReset();
      for (int n = 0; n <= DEPTH; n++) begin
         setRd(0, 20); step();
      end

      // Random traffic, first over a narrow window to force collisions.
      for (int n = 0; n < 300; n++) randStep(7);
      for (int n = 0; n < 300; n++) randStep(DEPTH - 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
